// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(21,16) encoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package hamming_pkg;

  localparam int K = 16;  // message bits
  localparam int R = 5;   // parity bits
  localparam int N = 21;  // codeword bits

  // Codeword position (1-based) of each message bit: the non-power-of-2 slots in order.
  localparam logic [4:0] DATA_POS [K] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };

  // True for the parity slots 1,2,4,8,16.
  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // One XOR stage realised as a 2:1 mux: b selects ~a, otherwise a passes.
  function automatic logic mux_xor(input logic a, input logic b);
    return b ? ~a : a;
  endfunction

endpackage

// File: rtl/hamming_parity_tree.sv
// Combinational parity generator: p[r] covers every data position with bit r set.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module hamming_parity_tree
  import hamming_pkg::*;
(
  input  logic [K-1:0] m,
  output logic [R-1:0] p
);

  // Each parity group is a linear chain of mux-XOR stages; bits outside the
  // group simply pass the running value through.  Unpacked storage keeps the
  // chain links as separate signals.
  logic chain [R][K+1];

  for (genvar r = 0; r < R; r++) begin : g_grp
    assign chain[r][0] = 1'b0;
    for (genvar i = 0; i < K; i++) begin : g_stage
      if (DATA_POS[i][r]) begin : g_tap
        assign chain[r][i+1] = mux_xor(chain[r][i], m[i]);
      end else begin : g_pass
        assign chain[r][i+1] = chain[r][i];
      end
    end
    assign p[r] = chain[r][K];
  end

endmodule

// File: rtl/mux_hamming.sv
// Registered Hamming(21,16) SEC encoder; optional overall parity with HAMMING_SECDED_EN.
// Latency: 1 cycle from in_valid/m to out_valid/e.
// Backpressure: none; a new word may be accepted every cycle.
module mux_hamming
  import hamming_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [K-1:0] m,
  output logic         out_valid,
`ifdef HAMMING_SECDED_EN
  output logic         e_par,
`endif
  output logic [N-1:0] e
);

  logic [R-1:0] p;
  logic [N-1:0] cw;

  hamming_parity_tree u_tree (
    .m (m),
    .p (p)
  );

  // Parity bits occupy the power-of-2 positions; p index is log2 of the position.
  for (genvar pos = 1; pos <= N; pos++) begin : g_pos
    if (is_pow2(pos)) begin : g_par
      assign cw[pos-1] = p[$clog2(pos)];
    end
  end

  // Message bits fill the remaining positions in ascending order.
  for (genvar i = 0; i < K; i++) begin : g_dat
    assign cw[DATA_POS[i]-1] = m[i];
  end

  // Output register: capture a codeword only on in_valid; valid is a 1-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      e         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e <= cw;
      end
    end
  end

`ifdef HAMMING_SECDED_EN
  // Overall parity across all codeword bits, built from the same mux-XOR stages.
  logic par_chain [N+1];
  assign par_chain[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_opar
    assign par_chain[i+1] = mux_xor(par_chain[i], cw[i]);
  end

  // Overall parity is registered alongside e so the pair always matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_par <= 1'b0;
    end else if (in_valid) begin
      e_par <= par_chain[N];
    end
  end
`endif

endmodule

// File: tb/tb_mux_hamming.sv
// Self-checking bench for mux_hamming: directed vectors plus a random sweep
// against a position-based reference encoder and a syndrome check.
module tb_mux_hamming;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] m;
  logic        out_valid;
  logic [20:0] e;
`ifdef HAMMING_SECDED_EN
  logic        e_par;
`endif

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_e;
  logic        exp_v;

  mux_hamming dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .m         (m),
    .out_valid (out_valid),
`ifdef HAMMING_SECDED_EN
    .e_par     (e_par),
`endif
    .e         (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place message bits at non-power-of-2 positions, then set each
  // parity so that its group (positions j with j&p != 0) has even parity.
  function automatic logic [20:0] ref_encode(input logic [15:0] msg);
    logic [20:0] cw;
    int k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = msg[k];
        k++;
      end
    end
    for (int pp = 1; pp <= 16; pp = pp * 2) begin
      logic b;
      b = 1'b0;
      for (int j = 1; j <= 21; j++)
        if (((j & pp) != 0) && (j != pp)) b = b ^ cw[j-1];
      cw[pp-1] = b;
    end
    return cw;
  endfunction

  // Syndrome = XOR of the positions of all set bits; zero for a valid codeword.
  function automatic int syndrome(input logic [20:0] w);
    int s;
    s = 0;
    for (int pos = 1; pos <= 21; pos++)
      if (w[pos-1]) s = s ^ pos;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input at the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic v, input logic [15:0] msg);
    @(negedge clk);
    in_valid = v;
    m        = msg;
    @(posedge clk);
    #1;
    exp_v = v;
    if (v) exp_e = ref_encode(msg);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(exp_v));
    check({tag, "_e"}, 32'(e), 32'(exp_e));
`ifdef HAMMING_SECDED_EN
    check({tag, "_par"}, 32'(e_par), 32'(^exp_e));
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    m        = 16'hFFFF;
    exp_e    = '0;
    exp_v    = 1'b0;

    // 1: reset dominates a valid input across several edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_e", 32'(e), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
`ifdef HAMMING_SECDED_EN
      check("rst_par", 32'(e_par), 32'h0);
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // 2: known vector
    step(1'b1, 16'h578D);
    check("vec578d", 32'(e), 32'h0A786C);
    check_model("vec578d_m");

    // 3: all ones / all zeros
    step(1'b1, 16'hFFFF);
    check("vecffff", 32'(e), 32'h1FFFFE);
    check_model("vecffff_m");
    step(1'b1, 16'h0000);
    check("vec0000", 32'(e), 32'h000000);
    check_model("vec0000_m");

    // 4: single low bit sets p1, p2, d0
    step(1'b1, 16'h0001);
    check("vec0001", 32'(e), 32'h000007);
    check_model("vec0001_m");

    // 5: back-to-back then idle; e holds the last word
    step(1'b1, 16'h578D);
    check("b2b0_valid", 32'(out_valid), 32'h1);
    check("b2b0_e", 32'(e), 32'h0A786C);
    step(1'b1, 16'hFFFF);
    check("b2b1_valid", 32'(out_valid), 32'h1);
    check("b2b1_e", 32'(e), 32'h1FFFFE);
    step(1'b0, 16'h1234);
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_hold", 32'(e), 32'h1FFFFE);
    step(1'b0, 16'hABCD);
    check_model("idle2");

    // 6: asynchronous reset mid-stream clears without a clock edge
    step(1'b1, 16'hBEEF);
    check_model("pre_arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_e", 32'(e), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    exp_e = '0;
    exp_v = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Random sweep: model comparison plus single-bit-error syndrome uniqueness
    for (int n = 0; n < 300; n++) begin
      logic [15:0] rm;
      int          fp;
      rm = 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), rm);
      check_model("rand");
      check("rand_syn0", 32'(syndrome(e)), 32'h0);
      fp = $urandom_range(1, 21);
      begin
        logic [20:0] bad;
        bad = e;
        bad[fp-1] = ~bad[fp-1];
        check("rand_synflip", 32'(syndrome(bad)), 32'(fp));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
